// File: rtl/z16_fetch_unit.sv
// z16_fetch_unit
// Instruction fetch stage of the Z16 core. Owns the fetch PC, issues 16-bit
// reads to instruction memory over a request/grant/response bus, buffers the
// returned words with their PCs in a DEPTH-entry FIFO and hands them to the
// decoder. A redirect flushes buffered and in-flight fetches and restarts
// fetching at a new PC.
//
// Parameters
//   RESET_PC  fetch address after reset (bit 0 ignored)
//   DEPTH     FIFO entries and total in-flight + buffered credit (2..8, pow2)
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   o_imem_req/o_imem_addr  read request and its halfword-aligned address
//   i_imem_gnt              request accepted this cycle
//   i_imem_rvalid/_rdata    read data, returned in request order
//   o_instr_valid/o_instr/o_instr_pc  FIFO head towards the decoder
//   i_instr_ready           decoder accepts the head
//   i_redirect/_pc          flush and restart fetch at i_redirect_pc
//
// Handshakes
//   Request bus: a request transfers in any cycle where o_imem_req and
//   i_imem_gnt are both high. Responses carry no ready; every i_imem_rvalid
//   pulse is consumed in the cycle it is presented.
//   Decoder bus: the head transfers in any cycle where o_instr_valid and
//   i_instr_ready are both high; while valid is high and ready is low the
//   head (o_instr, o_instr_pc) holds steady.
module z16_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [15:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_pc,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          CW         = AW + 1;
  localparam logic [15:0] RESET_PC_A = {RESET_PC[15:1], 1'b0};
  localparam logic [CW:0] DEPTH_C    = (CW + 1)'(DEPTH);

  logic          r_run;
  logic [15:0]   r_fetch_pc;
  logic [15:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [15:0]   r_mem_pc    [DEPTH];
  logic [15:0]   r_mem_instr [DEPTH];

  logic          resp_ok;
  logic          head_pop;
  logic          grant;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;

  // Bit 0 of the redirect target is forced to zero and never used.
  logic unused_redirect_bit;
  assign unused_redirect_bit = i_redirect_pc[0];

  always_comb begin
    resp_ok     = 1'b0;
    head_pop    = 1'b0;
    credit_used = '0;
    o_imem_req  = 1'b0;
    grant       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;

    // A response with nothing outstanding is a bus protocol error; ignore it.
    resp_ok  = i_imem_rvalid & (r_outstanding != '0);
    head_pop = (r_count != '0) & i_instr_ready;

    // Credit counts granted-but-unreturned reads plus buffered words. The
    // head leaving this cycle frees its slot before any new grant can
    // return (responses arrive at least one cycle after grant), so it is
    // released immediately; this is what sustains one word per cycle with
    // a single-cycle memory and DEPTH=2.
    credit_used = {1'b0, r_outstanding} + {1'b0, r_count}
                  - {{CW{1'b0}}, head_pop};

    o_imem_req = r_run & ~i_redirect & (credit_used < DEPTH_C);
    grant      = o_imem_req & i_imem_gnt;
    push       = resp_ok & (r_discard == '0) & ~i_redirect;
    pop        = head_pop & ~i_redirect;
  end

  assign o_imem_addr   = r_fetch_pc;
  assign o_instr_valid = (r_count != '0);
  assign o_instr       = r_mem_instr[r_rd_ptr];
  // With the FIFO empty, show the PC the next accepted word will carry.
  assign o_instr_pc    = o_instr_valid ? r_mem_pc[r_rd_ptr] : r_resp_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run         <= 1'b0;
      r_fetch_pc    <= RESET_PC_A;
      r_resp_pc     <= RESET_PC_A;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
      end
    end else begin
      r_run <= 1'b1;
      if (i_redirect) begin
        // Every read still in flight after this cycle belongs to the old
        // stream; a response arriving right now is already dropped.
        r_fetch_pc    <= {i_redirect_pc[15:1], 1'b0};
        r_resp_pc     <= {i_redirect_pc[15:1], 1'b0};
        r_outstanding <= r_outstanding - CW'(resp_ok);
        r_discard     <= r_outstanding - CW'(resp_ok);
        r_count       <= '0;
        r_rd_ptr      <= '0;
        r_wr_ptr      <= '0;
      end else begin
        if (grant) begin
          r_fetch_pc <= r_fetch_pc + 16'd2;
        end
        r_outstanding <= r_outstanding + CW'(grant) - CW'(resp_ok);
        if (resp_ok && (r_discard != '0)) begin
          r_discard <= r_discard - 1'b1;
        end
        if (push) begin
          r_mem_pc[r_wr_ptr]    <= r_resp_pc;
          r_mem_instr[r_wr_ptr] <= i_imem_rdata;
          r_wr_ptr              <= r_wr_ptr + 1'b1;
          r_resp_pc             <= r_resp_pc + 16'd2;
        end
        if (pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= r_count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_z16_fetch_unit.sv
// Bench for z16_fetch_unit: table-driven per-cycle vectors for the streaming,
// stall and grant-stall cases, hand-written sequences for redirects, and a
// second instance with RESET_PC=16'hFFFC for address wrap.
module tb_z16_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst_n = 1'b0;
  logic        req;
  logic [15:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [15:0] rdata = '0;
  logic        ivalid;
  logic [15:0] instr;
  logic [15:0] ipc;
  logic        ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;

  // wrap instance
  logic        w_rst_n = 1'b0;
  logic        w_req;
  logic [15:0] w_addr;
  logic        w_gnt = 1'b1;
  logic        w_rvalid = 1'b0;
  logic [15:0] w_rdata = '0;
  logic        w_ivalid;
  logic [15:0] w_instr;
  logic [15:0] w_ipc;
  logic        w_ready = 1'b1;
  logic        w_redirect = 1'b0;
  logic [15:0] w_redirect_pc = '0;

  z16_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
    .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_instr_valid(ivalid), .o_instr(instr), .o_instr_pc(ipc),
    .i_instr_ready(ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc)
  );

  z16_fetch_unit #(.RESET_PC(16'hFFFC), .DEPTH(2)) u_wrap (
    .i_clk(clk), .i_rst_n(w_rst_n),
    .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_gnt(w_gnt),
    .i_imem_rvalid(w_rvalid), .i_imem_rdata(w_rdata),
    .o_instr_valid(w_ivalid), .o_instr(w_instr), .o_instr_pc(w_ipc),
    .i_instr_ready(w_ready), .i_redirect(w_redirect), .i_redirect_pc(w_redirect_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;

  typedef struct {
    logic [15:0] a;
    int          due;
  } pend_t;
  pend_t pend_q[$];

  logic [15:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        ready;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;
  vec_t vecs[$];

  logic [15:0] first_grant;
  logic        seen_grant;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void add_vec(input logic r, input logic g, input logic rd,
                                  input logic er, input logic [15:0] ea,
                                  input logic ev, input logic [15:0] ep);
    vec_t v;
    v.rst = r; v.gnt = g; v.ready = rd;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    vecs.push_back(v);
  endfunction

  // Asserts reset mid-cycle, checks outputs react at once, releases reset
  // mid-cycle so the bench lands at the start of cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
    redirect = 1'b0;
    pend_q.delete();
    #1;
    check("rst_req",   {15'b0, req},    16'h0000);
    check("rst_addr",  addr,            16'h0000);
    check("rst_valid", {15'b0, ivalid}, 16'h0000);
    check("rst_instr", instr,           16'h0000);
    check("rst_pc",    ipc,             16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Advances one cycle and plays the memory: each granted read returns
  // lat cycles after its grant, in order.
  task automatic step();
    logic        g;
    logic [15:0] a;
    pend_t       p;
    g = req & gnt;
    a = addr;
    @(posedge clk);
    #1;
    if (g) begin
      p.a = a;
      p.due = cyc + lat;
      pend_q.push_back(p);
    end
    cyc++;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      rvalid = 1'b1;
      rdata = word_of(p.a);
    end else begin
      rvalid = 1'b0;
      rdata = '0;
    end
  endtask

  // Runs until every expected PC has been accepted by the decoder side.
  task automatic drain(input int max_cycles, input string tag);
    logic [15:0] e;
    for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) begin
      #1;
      if (req && gnt && !seen_grant) begin
        first_grant = addr;
        seen_grant = 1'b1;
      end
      if (ivalid && ready) begin
        e = exp_q.pop_front();
        check({tag, "_pc"}, ipc, e);
        check({tag, "_instr"}, instr, word_of(e));
      end
      step();
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d instructions still expected, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [15:0] wrap_seq [4];
    int          ngr;
    int          na;
    int          np;
    logic        wg;
    logic [15:0] wa;

    // Streaming: gnt=1, 1-cycle memory, ready=1.
    add_vec(1, 1, 1, 0, 16'h0000, 0, 16'h0000);
    add_vec(0, 1, 1, 1, 16'h0000, 0, 16'h0000);
    add_vec(0, 1, 1, 1, 16'h0002, 0, 16'h0000);
    add_vec(0, 1, 1, 1, 16'h0004, 1, 16'h0000);
    add_vec(0, 1, 1, 1, 16'h0006, 1, 16'h0002);
    add_vec(0, 1, 1, 1, 16'h0008, 1, 16'h0004);
    add_vec(0, 1, 1, 1, 16'h000A, 1, 16'h0006);
    // Decoder stall: two grants fill the credit, head held, then resume at 4.
    add_vec(1, 1, 0, 0, 16'h0000, 0, 16'h0000);
    add_vec(0, 1, 0, 1, 16'h0000, 0, 16'h0000);
    add_vec(0, 1, 0, 1, 16'h0002, 0, 16'h0000);
    add_vec(0, 1, 0, 0, 16'h0004, 1, 16'h0000);
    add_vec(0, 1, 0, 0, 16'h0004, 1, 16'h0000);
    add_vec(0, 1, 0, 0, 16'h0004, 1, 16'h0000);
    add_vec(0, 1, 1, 1, 16'h0004, 1, 16'h0000);
    add_vec(0, 1, 1, 1, 16'h0006, 1, 16'h0002);
    add_vec(0, 1, 1, 1, 16'h0008, 1, 16'h0004);
    // Grant held low for 5 cycles, then normal flow.
    add_vec(1, 0, 1, 0, 16'h0000, 0, 16'h0000);
    for (int i = 0; i < 5; i++) add_vec(0, 0, 1, 1, 16'h0000, 0, 16'h0000);
    add_vec(0, 1, 1, 1, 16'h0000, 0, 16'h0000);
    add_vec(0, 1, 1, 1, 16'h0002, 0, 16'h0000);
    add_vec(0, 1, 1, 1, 16'h0004, 1, 16'h0000);
    add_vec(0, 1, 1, 1, 16'h0006, 1, 16'h0002);

    lat = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      gnt = vecs[i].gnt;
      ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d_req", i),   {15'b0, req},    {15'b0, vecs[i].exp_req});
      check($sformatf("vec%0d_addr", i),  addr,            vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), {15'b0, ivalid}, {15'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_pc", i),    ipc,             vecs[i].exp_pc);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_instr", i), instr, word_of(vecs[i].exp_pc));
      end
      step();
    end

    // Redirect with two reads in flight on a 3-cycle memory.
    lat = 3;
    do_reset();
    gnt = 1'b1;
    ready = 1'b1;
    repeat (3) step();
    #1;
    check("rd3_credit_full_req", {15'b0, req}, 16'h0000);
    redirect = 1'b1;
    redirect_pc = 16'h1235;
    #1;
    check("rd3_req_during_redirect", {15'b0, req}, 16'h0000);
    step();
    redirect = 1'b0;
    #1;
    check("rd3_valid_after_redirect", {15'b0, ivalid}, 16'h0000);
    seen_grant = 1'b0;
    first_grant = 16'hDEAD;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h1236);
    exp_q.push_back(16'h1238);
    drain(40, "rd3");
    check("rd3_first_grant", first_grant, 16'h1234);

    // Redirect coinciding with a response and a pop, one word buffered.
    lat = 1;
    do_reset();
    gnt = 1'b1;
    ready = 1'b1;
    repeat (3) step();
    #1;
    check("rdc_setup_valid", {15'b0, ivalid}, 16'h0001);
    check("rdc_setup_pc", ipc, 16'h0000);
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    #1;
    check("rdc_req_during_redirect", {15'b0, req}, 16'h0000);
    step();
    redirect = 1'b0;
    ready = 1'b0;
    #1;
    check("rdc_valid_after_redirect", {15'b0, ivalid}, 16'h0000);
    check("rdc_addr_after_redirect", addr, 16'h0100);
    ngr = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (req && gnt) ngr++;
      step();
    end
    #1;
    check("rdc_grants_with_full_credit", 16'(ngr), 16'd2);
    check("rdc_head_pc", ipc, 16'h0100);
    check("rdc_head_instr", instr, word_of(16'h0100));
    ready = 1'b1;
    seen_grant = 1'b0;
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0102);
    exp_q.push_back(16'h0104);
    drain(30, "rdc");

    // Address wrap from RESET_PC=16'hFFFC.
    wrap_seq[0] = 16'hFFFC;
    wrap_seq[1] = 16'hFFFE;
    wrap_seq[2] = 16'h0000;
    wrap_seq[3] = 16'h0002;
    #1;
    check("wrap_rst_req",   {15'b0, w_req},    16'h0000);
    check("wrap_rst_addr",  w_addr,            16'hFFFC);
    check("wrap_rst_valid", {15'b0, w_ivalid}, 16'h0000);
    check("wrap_rst_instr", w_instr,           16'h0000);
    check("wrap_rst_pc",    w_ipc,             16'hFFFC);
    w_rst_n = 1'b1;
    na = 0;
    np = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (w_req && na < 4) begin
        check($sformatf("wrap_addr%0d", na), w_addr, wrap_seq[na]);
        na++;
      end
      if (w_ivalid && np < 4) begin
        check($sformatf("wrap_pc%0d", np), w_ipc, wrap_seq[np]);
        check($sformatf("wrap_instr%0d", np), w_instr, word_of(wrap_seq[np]));
        np++;
      end
      wg = w_req & w_gnt;
      wa = w_addr;
      @(posedge clk);
      #1;
      w_rvalid = wg;
      w_rdata = word_of(wa);
    end
    check("wrap_addr_count", 16'(na), 16'd4);
    check("wrap_pc_count", 16'(np), 16'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
